// File: rtl/microseq_pkg.sv
// rtl/microseq_pkg.sv - microaddress encoding, op-codes and instruction classes for microseq
package microseq_pkg;

    // Values are the control-memory addresses; upc drives that memory directly.
    typedef enum logic [3:0] {
        UPC_FETCH    = 4'd0,
        UPC_DECODE   = 4'd1,
        UPC_MEMADR   = 4'd2,
        UPC_MEMREAD  = 4'd3,
        UPC_MEMWRITE = 4'd4,
        UPC_MEMWB    = 4'd5,
        UPC_EXECR    = 4'd6,
        UPC_EXECI    = 4'd7,
        UPC_ALUWB    = 4'd8,
        UPC_BRANCH   = 4'd9
    } upc_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam int FUNCT_IMM_BIT = 5;
    localparam int FUNCT_LD_BIT  = 0;

    typedef enum logic [1:0] {
        CLS_DP,
        CLS_MEM,
        CLS_BR,
        CLS_ILL
    } instr_class_e;

    function automatic instr_class_e classify(input logic [1:0] op);
        instr_class_e cls;
        case (op)
            OP_DP:   cls = CLS_DP;
            OP_MEM:  cls = CLS_MEM;
            OP_BR:   cls = CLS_BR;
            default: cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/microseq_dispatch.sv
// rtl/microseq_dispatch.sv - combinational DECODE dispatch table (replaceable by a ROM)
module microseq_dispatch
    import microseq_pkg::*;
(
    input  logic [1:0] op_i,
    input  logic       funct_imm_i,
    output upc_e       next_upc_o
);

    always_comb begin
        next_upc_o = UPC_FETCH;
        case (classify(op_i))
            CLS_DP:  next_upc_o = funct_imm_i ? UPC_EXECI : UPC_EXECR;
            CLS_MEM: next_upc_o = UPC_MEMADR;
            CLS_BR:  next_upc_o = UPC_BRANCH;
            default: next_upc_o = UPC_FETCH;
        endcase
    end

endmodule

// File: rtl/microseq.sv
// rtl/microseq.sv - microprogram sequencer: upc state machine, retire counter, illegal flag
module microseq
    import microseq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    input  logic        halt,
    output logic [3:0]  upc,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic        stall
);

    upc_e        upc_q, upc_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  funct_q, funct_d;
    logic        illegal_q, illegal_d;
    logic        done_q, done_d;
    logic [31:0] count_q, count_d;
    upc_e        dispatch_upc;

    microseq_dispatch u_dispatch (
        .op_i        (op),
        .funct_imm_i (funct[FUNCT_IMM_BIT]),
        .next_upc_o  (dispatch_upc)
    );

    always_comb begin
        upc_d     = upc_q;
        op_d      = op_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        count_d   = count_q;

        case (upc_q)
            UPC_FETCH: begin
                if (mem_ready && !halt) upc_d = UPC_DECODE;
            end
            UPC_DECODE: begin
                upc_d   = dispatch_upc;
                op_d    = op;
                funct_d = funct;
                if (op == OP_ILL) illegal_d = 1'b1;
            end
            // Uses the funct captured at DECODE; the live input may already be the next instruction.
            UPC_MEMADR: begin
                upc_d = funct_q[FUNCT_LD_BIT] ? UPC_MEMREAD : UPC_MEMWRITE;
            end
            UPC_MEMREAD: begin
                if (mem_ready) upc_d = UPC_MEMWB;
            end
            UPC_MEMWRITE: begin
                if (mem_ready) begin
                    upc_d  = UPC_FETCH;
                    done_d = 1'b1;
                end
            end
            UPC_MEMWB, UPC_ALUWB, UPC_BRANCH: begin
                upc_d  = UPC_FETCH;
                done_d = 1'b1;
            end
            UPC_EXECR, UPC_EXECI: begin
                upc_d = UPC_ALUWB;
            end
            default: begin
                upc_d = UPC_FETCH;
            end
        endcase

        if (done_d) count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            upc_q     <= UPC_FETCH;
            op_q      <= 2'b00;
            funct_q   <= 6'b000000;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            upc_q     <= upc_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    // Captured op and the remaining funct bits are kept for control-memory extensions.
    logic unused_capture;
    assign unused_capture = ^{op_q, funct_q[5:1]};

    assign upc         = upc_q;
    assign instr_done  = done_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;
    assign stall       = ((upc_q == UPC_FETCH) || (upc_q == UPC_MEMREAD) ||
                          (upc_q == UPC_MEMWRITE)) && !mem_ready;

endmodule

// File: tb/tb_microseq.sv
// tb/tb_microseq.sv - table-driven directed bench for microseq
module tb_microseq;

    logic        clk;
    logic        reset;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        halt;
    logic [3:0]  upc;
    logic        instr_done;
    logic        illegal;
    logic [31:0] instr_count;
    logic        stall;

    int errors = 0;
    int checks = 0;

    microseq dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .halt        (halt),
        .upc         (upc),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .instr_count (instr_count),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        mr;
        logic        halt;
        logic        ex_stall;
        logic [3:0]  ex_upc;
        logic        ex_done;
        logic        ex_ill;
        logic [31:0] ex_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] o, input logic [5:0] f, input logic m,
                                input logic h, input logic s, input logic [3:0] u,
                                input logic d, input logic il, input logic [31:0] c);
        vec_t v;
        v.op = o; v.funct = f; v.mr = m; v.halt = h; v.ex_stall = s;
        v.ex_upc = u; v.ex_done = d; v.ex_ill = il; v.ex_cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stall is checked before the edge against the state it reflects; the rest after the edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        op = v.op; funct = v.funct; mem_ready = v.mr; halt = v.halt;
        #1;
        chk("stall", {31'd0, stall}, {31'd0, v.ex_stall});
        @(posedge clk);
        #1;
        chk("upc", {28'd0, upc}, {28'd0, v.ex_upc});
        chk("instr_done", {31'd0, instr_done}, {31'd0, v.ex_done});
        chk("illegal", {31'd0, illegal}, {31'd0, v.ex_ill});
        chk("instr_count", instr_count, v.ex_cnt);
    endtask

    initial begin
        // ALU register
        tbl.push_back(mk(2'd0, 6'b000000, 1, 0, 0, 4'd1, 0, 0, 0));
        tbl.push_back(mk(2'd0, 6'b000000, 1, 0, 0, 4'd6, 0, 0, 0));
        tbl.push_back(mk(2'd0, 6'b000000, 1, 0, 0, 4'd8, 0, 0, 0));
        tbl.push_back(mk(2'd0, 6'b000000, 1, 0, 0, 4'd0, 1, 0, 1));
        // LDR with two wait cycles; live funct flips after DECODE
        tbl.push_back(mk(2'd1, 6'b011001, 1, 0, 0, 4'd1, 0, 0, 1));
        tbl.push_back(mk(2'd1, 6'b011001, 1, 0, 0, 4'd2, 0, 0, 1));
        tbl.push_back(mk(2'd1, 6'b000000, 1, 0, 0, 4'd3, 0, 0, 1));
        tbl.push_back(mk(2'd1, 6'b000000, 0, 0, 1, 4'd3, 0, 0, 1));
        tbl.push_back(mk(2'd1, 6'b000000, 0, 0, 1, 4'd3, 0, 0, 1));
        tbl.push_back(mk(2'd1, 6'b000000, 1, 0, 0, 4'd5, 0, 0, 1));
        tbl.push_back(mk(2'd1, 6'b000000, 1, 0, 0, 4'd0, 1, 0, 2));
        // STR (one wait) then branch
        tbl.push_back(mk(2'd1, 6'b011000, 1, 0, 0, 4'd1, 0, 0, 2));
        tbl.push_back(mk(2'd1, 6'b011000, 1, 0, 0, 4'd2, 0, 0, 2));
        tbl.push_back(mk(2'd1, 6'b000001, 1, 0, 0, 4'd4, 0, 0, 2));
        tbl.push_back(mk(2'd1, 6'b000000, 0, 0, 1, 4'd4, 0, 0, 2));
        tbl.push_back(mk(2'd1, 6'b000000, 1, 0, 0, 4'd0, 1, 0, 3));
        tbl.push_back(mk(2'd2, 6'b000000, 1, 0, 0, 4'd1, 0, 0, 3));
        tbl.push_back(mk(2'd2, 6'b000000, 1, 0, 0, 4'd9, 0, 0, 3));
        tbl.push_back(mk(2'd2, 6'b000000, 1, 0, 0, 4'd0, 1, 0, 4));
        // FETCH waiting on memory, then illegal op
        tbl.push_back(mk(2'd3, 6'b000000, 0, 0, 1, 4'd0, 0, 0, 4));
        tbl.push_back(mk(2'd3, 6'b000000, 1, 0, 0, 4'd1, 0, 0, 4));
        tbl.push_back(mk(2'd3, 6'b000000, 1, 0, 0, 4'd0, 0, 1, 4));
        tbl.push_back(mk(2'd0, 6'b000000, 0, 0, 1, 4'd0, 0, 1, 4));
        // ALU immediate
        tbl.push_back(mk(2'd0, 6'b100000, 1, 0, 0, 4'd1, 0, 1, 4));
        tbl.push_back(mk(2'd0, 6'b100000, 1, 0, 0, 4'd7, 0, 1, 4));
        tbl.push_back(mk(2'd0, 6'b000000, 1, 0, 0, 4'd8, 0, 1, 4));
        tbl.push_back(mk(2'd0, 6'b000000, 1, 0, 0, 4'd0, 1, 1, 5));
        // second illegal keeps the flag; halt in FETCH holds without stall
        tbl.push_back(mk(2'd3, 6'b000000, 1, 0, 0, 4'd1, 0, 1, 5));
        tbl.push_back(mk(2'd3, 6'b000000, 1, 0, 0, 4'd0, 0, 1, 5));
        tbl.push_back(mk(2'd0, 6'b000000, 1, 1, 0, 4'd0, 0, 1, 5));

        op = 2'd0; funct = 6'd0; mem_ready = 1'b0; halt = 1'b0; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_upc", {28'd0, upc}, 32'd0);
        chk("rst_done", {31'd0, instr_done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // halt raised during EXECI: instruction still retires, then FETCH holds
        apply(mk(2'd0, 6'b000000, 1, 0, 0, 4'd1, 0, 1, 5));
        apply(mk(2'd0, 6'b100000, 1, 0, 0, 4'd7, 0, 1, 5));
        apply(mk(2'd0, 6'b000000, 1, 1, 0, 4'd8, 0, 1, 5));
        apply(mk(2'd0, 6'b000000, 1, 1, 0, 4'd0, 1, 1, 6));
        for (int k = 0; k < 3; k++) apply(mk(2'd0, 6'b000000, 1, 1, 0, 4'd0, 0, 1, 6));
        apply(mk(2'd0, 6'b000000, 1, 0, 0, 4'd1, 0, 1, 6));

        // reset while stalled in MEMREAD
        apply(mk(2'd1, 6'b000001, 1, 0, 0, 4'd2, 0, 1, 6));
        apply(mk(2'd1, 6'b000001, 1, 0, 0, 4'd3, 0, 1, 6));
        apply(mk(2'd1, 6'b000001, 0, 0, 1, 4'd3, 0, 1, 6));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midstall_rst_upc", {28'd0, upc}, 32'd0);
        chk("midstall_rst_count", instr_count, 32'd0);
        chk("midstall_rst_illegal", {31'd0, illegal}, 32'd0);
        chk("midstall_rst_done", {31'd0, instr_done}, 32'd0);

        // preload the counter to all-ones while halted in FETCH, then retire one branch
        @(negedge clk);
        reset = 1'b1; halt = 1'b1; mem_ready = 1'b1;
        force dut.count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("halt_hold_upc", {28'd0, upc}, 32'd0);
        chk("halt_no_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        release dut.count_q;
        #1;
        chk("preload_count", instr_count, 32'hFFFF_FFFF);
        apply(mk(2'd2, 6'b000000, 1, 0, 0, 4'd1, 0, 0, 32'hFFFF_FFFF));
        apply(mk(2'd2, 6'b000000, 1, 0, 0, 4'd9, 0, 0, 32'hFFFF_FFFF));
        apply(mk(2'd2, 6'b000000, 1, 0, 0, 4'd0, 1, 0, 32'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
